// File: rtl/data_mem_resp_if.sv
// Bus between the control unit and the data memory responder.
// Carries the level-sensitive request (mRD/mWR, addr, wdata) and the response
// (rdata, ready pulse, busy, err). 32-bit byte address, 32-bit data.
//
// Signals
//   mRD, mWR : request strobes from the control unit (levels, sampled when idle)
//   addr     : byte address
//   wdata    : write data captured with the request
//   rdata    : read data, held until the next completed read
//   ready    : one-cycle completion pulse
//   busy     : a request is in flight
//   err      : one-cycle fault pulse coincident with ready
interface data_mem_resp_if;
  logic        mRD;
  logic        mWR;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  // Control-unit side.
  modport master (
    output mRD,
    output mWR,
    output addr,
    output wdata,
    input  rdata,
    input  ready,
    input  busy,
    input  err
  );

  // Memory side.
  modport slave (
    input  mRD,
    input  mWR,
    input  addr,
    input  wdata,
    output rdata,
    output ready,
    output busy,
    output err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed wait-state response handshake.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accepting edge.
// Backpressure: none; requests are ignored while busy, next accept is the cycle after ready.
//
// Ports
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous active-low reset (storage is not cleared by it)
//   bus  : data_mem_resp_if.slave (mRD, mWR, addr, wdata in; rdata, ready, busy, err out)
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words, power of two 4..1024
//   WAIT_CYCLES : wait states before the response, 0..15
//
// Build option
//   DMEM_ALIGN_CHECK_EN : when defined, a request with addr[1:0]!=0 is faulted
//   (no write, rdata kept, err with ready). When undefined addr[1:0] is ignored
//   and only a simultaneous mRD+mWR faults.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_resp_if.slave bus
);

  localparam int AW      = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q;
  logic [3:0]      cnt_q;

  // Request captured at acceptance; held while WAIT/RESP so bus changes are ignored.
  logic            op_rd_q;
  logic            op_wr_q;
  logic            fault_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  // Registered outputs.
  logic [31:0]     rdata_q;
  logic            ready_q;
  logic            busy_q;
  logic            err_q;

  // Storage starts at zero and is never touched by reset.
  logic [31:0]     mem_q [DEPTH_WORDS] = '{default: 32'h0};

  // ---------------------------------------------------------------------------
  // Next values of the captured request.
  // In IDLE they follow the bus so that a zero-wait request can complete on the
  // same edge that accepts it; elsewhere they hold the captured copy.
  // ---------------------------------------------------------------------------
  logic            op_rd_d;
  logic            op_wr_d;
  logic            fault_d;
  logic [AW-1:0]   idx_d;
  logic [31:0]     wdata_d;

  always_comb begin
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    if (state_q == S_IDLE) begin
      op_rd_d = bus.mRD;
      op_wr_d = bus.mWR;
      idx_d   = bus.addr[AW+1:2];
      wdata_d = bus.wdata;
      // Read and write together is ambiguous: complete it as an error.
      fault_d = bus.mRD & bus.mWR;
`ifdef DMEM_ALIGN_CHECK_EN
      if (bus.addr[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
`endif
    end
  end

  // Address bits outside the word index are don't-care (upper bits wrap the
  // storage; the byte offset only matters when the alignment check is built in).
`ifdef DMEM_ALIGN_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.addr[31:AW+2];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};
`endif

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic commit;
  logic mem_we;

  assign accept = (state_q == S_IDLE) && (bus.mRD || bus.mWR);

  // commit marks the edge that enters RESP: straight from IDLE with no wait
  // states, otherwise the WAIT cycle whose counter has run down to 1.
  assign commit = NO_WAIT ? accept : ((state_q == S_WAIT) && (cnt_q == 4'd1));

  // rst gates the write so an accept seen while reset is held cannot store.
  assign mem_we = commit && op_wr_d && !fault_d && rst;

  // ---------------------------------------------------------------------------
  // Storage write port (no reset: contents survive rst)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;

      // ready/err are single-cycle pulses unless a completion re-arms them.
      ready_q <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            cnt_q  <= 4'(WAIT_CYCLES);
            state_q <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase

      // Completion: response is visible for the whole RESP cycle. A faulted
      // request leaves rdata untouched; the write itself is in the storage block.
      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= fault_d;
        if (op_rd_d && !fault_d) begin
          rdata_q <= mem_q[idx_d];
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: one default instance (WAIT_CYCLES=2)
// and one zero-wait instance, both checked against a word-array reference model.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_z ();

  data_mem_resp u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  data_mem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: plain word arrays and last-read registers per instance.
  logic [31:0] mem_m   [2][64];
  logic [31:0] rdata_m [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus_a.mRD = rd; bus_a.mWR = wr; bus_a.addr = a; bus_a.wdata = d;
    end else begin
      bus_z.mRD = rd; bus_z.mWR = wr; bus_z.addr = a; bus_z.wdata = d;
    end
  endtask

  function automatic logic [31:0] rdata_of(input int sel);
    return (sel == 0) ? bus_a.rdata : bus_z.rdata;
  endfunction

  // {ready, busy, err}
  function automatic logic [31:0] flags_of(input int sel);
    if (sel == 0) return {29'd0, bus_a.ready, bus_a.busy, bus_a.err};
    return {29'd0, bus_z.ready, bus_z.busy, bus_z.err};
  endfunction

  // One complete request; called and returning just after a falling edge.
  // Checks every cycle of the transaction so early or late ready is caught.
  task automatic run_req(input int sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
    int   waits;
    bit   err_e;
    int   idx;
    waits = (sel == 0) ? 2 : 0;
    err_e = (rd && wr) || (ALIGN_EN && (a[1:0] != 2'b00));
    idx   = int'((a >> 2) % 64);
    if (!err_e) begin
      if (wr) mem_m[sel][idx] = d;
      if (rd) rdata_m[sel] = mem_m[sel][idx];
    end
    drive(sel, rd, wr, a, d);
    @(posedge clk);
    #1;
    // Bus noise while the request is in flight must not matter.
    drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    for (int k = 1; k <= waits + 1; k++) begin
      @(negedge clk);
      if (k == waits + 1) begin
        check({tag, ".resp_flags"}, flags_of(sel), {29'd0, 1'b1, 1'b1, err_e});
        check({tag, ".rdata"}, rdata_of(sel), rdata_m[sel]);
      end else begin
        check({tag, ".wait_flags"}, flags_of(sel), 32'b010);
      end
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check({tag, ".idle_flags"}, flags_of(sel), 32'b000);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rdata_m[s] = 32'h0;
      for (int w = 0; w < 64; w++) mem_m[s][w] = 32'h0;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state.
    #3;
    check("rst.a_flags", flags_of(0), 32'b000);
    check("rst.a_rdata", rdata_of(0), 32'h0);
    check("rst.z_flags", flags_of(1), 32'b000);
    check("rst.z_rdata", rdata_of(1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Default latency write/read.
    run_req(0, 0, 1, 32'h10, 32'hDEADBEEF, "a.wr10");
    run_req(0, 1, 0, 32'h10, 32'h0,        "a.rd10");
    check("a.rd10.value", rdata_of(0), 32'hDEADBEEF);

    // Zero wait states.
    run_req(1, 0, 1, 32'h0, 32'h12345678, "z.wr0");
    run_req(1, 1, 0, 32'h0, 32'h0,        "z.rd0");
    check("z.rd0.value", rdata_of(1), 32'h12345678);

    // Read and write together: error, nothing stored.
    run_req(0, 1, 1, 32'h20, 32'h1, "a.both20");
    run_req(0, 1, 0, 32'h20, 32'h0, "a.rd20");
    check("a.rd20.value", rdata_of(0), 32'h0);

    // Address wrap modulo storage depth.
    run_req(0, 0, 1, 32'h100, 32'hA5A5A5A5, "a.wr100");
    run_req(0, 1, 0, 32'h0,   32'h0,        "a.rd0wrap");
    check("a.rd0wrap.value", rdata_of(0), 32'hA5A5A5A5);

    // Misaligned write to word 0x10.
    run_req(0, 0, 1, 32'h13, 32'hCAFEF00D, "a.wr13");
    run_req(0, 1, 0, 32'h10, 32'h0,        "a.rd10b");
    check("a.rd10b.value", rdata_of(0), ALIGN_EN ? 32'hDEADBEEF : 32'hCAFEF00D);

    // Reset during WAIT aborts the write.
    run_req(0, 0, 1, 32'h40, 32'h11112222, "a.wr40");
    drive(0, 1'b0, 1'b1, 32'h40, 32'h33334444);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("abort.busy_before", flags_of(0), 32'b010);
    rst = 1'b0;
    #1;
    check("abort.flags", flags_of(0), 32'b000);
    check("abort.rdata", rdata_of(0), 32'h0);
    rdata_m[0] = 32'h0;
    rdata_m[1] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("abort.no_ready", flags_of(0), 32'b000);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_req(0, 1, 0, 32'h40, 32'h0, "a.rd40");
    check("a.rd40.value", rdata_of(0), 32'h11112222);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int          sel;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      sel = n % 2;
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        rd = 1'b1; wr = 1'b1;
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_req(sel, rd, wr, a, $urandom, sel == 0 ? "rnd.a" : "rnd.z");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, meaning number of 32-bit storage words; power of two, 4..1024.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before response; range 0..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mRD  input  1  read request from the control unit; level, sampled in IDLE.
REQ-006 mWR  input  1  write request from the control unit; level, sampled in IDLE.
REQ-007 addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-008 wdata  input  32  write data, captured with the request.
REQ-009 rdata  output  32  read data; valid while ready=1, held until the next completed read.
REQ-010 ready  output  1  one-cycle completion pulse per accepted request.
REQ-011 busy  output  1  high in WAIT and RESP states.
REQ-012 err  output  1  one-cycle error pulse coincident with ready for a faulted request.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 IDLE: if mRD or mWR is high at a rising edge, the block SHALL capture op, addr and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 WAIT: counter SHALL decrement each cycle; move to RESP on the edge where the counter reaches 1.
REQ-016 Latency: ready SHALL assert exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-017 RESP: ready=1 for one cycle, then go to IDLE unconditionally; a new request is accepted no earlier than the cycle after ready.
REQ-018 Write SHALL commit to storage on the edge entering RESP; a read SHALL load rdata on the same edge.
REQ-019 mRD, mWR, addr, wdata changes during WAIT/RESP SHALL be ignored.
REQ-020 mRD and mWR both high at acceptance: no write, rdata unchanged, err=1 with ready.
REQ-021 Address above storage range SHALL wrap modulo DEPTH_WORDS (upper bits ignored).
REQ-022 Read immediately after write to the same word SHALL return the new data.
REQ-023 Storage contents SHALL be zero at simulation start.

Reset
REQ-024 rst=0 SHALL force IDLE, counter=0, ready=0, busy=0, err=0, rdata=0 immediately.
REQ-025 Reset mid-operation SHALL abort the request with no write and no ready pulse.
REQ-026 Storage contents SHALL NOT be altered by rst.

Configuration
REQ-027 Macro DMEM_ALIGN_CHECK_EN defined: addr[1:0]!=0 at acceptance SHALL suppress the write, leave rdata unchanged, and assert err with ready (normal latency).
REQ-028 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored and err SHALL assert only per REQ-020.

Verification
REQ-029 Defaults; mWR=1 addr=0x10 wdata=0xDEADBEEF, then mRD=1 addr=0x10 -> each ready 3 cycles after acceptance, rdata=0xDEADBEEF, err=0.
REQ-030 WAIT_CYCLES=0; write 0x12345678 to 0x0, read 0x0 -> ready 1 cycle after each acceptance, rdata=0x12345678.
REQ-031 mRD=mWR=1 addr=0x20 wdata=0x1 -> ready=1 err=1; subsequent read of 0x20 returns 0x00000000.
REQ-032 Write 0xA5A5A5A5 to addr=0x100 (DEPTH_WORDS=64) -> read addr=0x0 returns 0xA5A5A5A5.
REQ-033 Write accepted, rst pulsed low during WAIT -> no ready, busy=0 at once; read of same address returns prior value.
REQ-034 DMEM_ALIGN_CHECK_EN defined; mWR=1 addr=0x13 -> err=1 with ready, word 0x10 unchanged; undefined -> write lands in word 0x10, err=0.
